// File: rtl/vga_console_if.sv
// Byte-stream handshake into the text console writer.
// The source drives valid/data; the console drives ready.
interface vga_console_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;

  modport master (
    output char_valid,
    output char_data,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_data,
    output char_ready
  );
endinterface

// File: rtl/vga_console.sv
// Character-stream writer for the 70x30 text-mode RAM.
// Scrolls by rotating top_row and blanking the recycled row.
module vga_console (
  input  logic         sys_clk,
  input  logic         rst,
  vga_console_if.slave chr,
  output logic         ram_wren,
  output logic [11:0]  ram_addr,
  output logic [7:0]   ram_data,
  output logic [6:0]   cursor_x,
  output logic [4:0]   cursor_y,
  output logic [4:0]   top_row
);

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [6:0] LAST_COL = 7'd69;
  localparam logic [4:0] LAST_ROW = 5'd29;
  localparam logic [11:0] LAST_CELL = 12'd2099;
  localparam logic [11:0] LINE_END = 12'd69;

  localparam logic [1:0] CLEAR_ALL  = 2'd0;
  localparam logic [1:0] IDLE       = 2'd1;
  localparam logic [1:0] CLEAR_LINE = 2'd2;

  logic [1:0]  state;
  logic [11:0] cnt;
  logic [11:0] clr_base;

  logic        accept;
  logic        is_ff;
  logic        is_lf;
  logic        is_cr;
  logic        is_bs;
  logic        is_print;
  logic        x_last;
  logic        scroll;
  logic        do_adv;

  logic [5:0]  row_sum;
  logic [4:0]  prow;
  logic [4:0]  top_nxt;
  logic [11:0] row_base;
  logic [11:0] top_base;
  logic [6:0]  col_dec;
  logic [11:0] wr_addr;
  logic [11:0] bs_addr;

  function automatic logic [11:0] mul70(
    input logic [4:0] r
  );
    logic [11:0] w;
    w = {7'd0, r};
    return (w << 6) + (w << 2) + (w << 1);
  endfunction

  assign chr.char_ready = (state == IDLE);
  assign accept = chr.char_valid & chr.char_ready;

  // Classify the incoming byte.
  always_comb begin
    is_ff    = (chr.char_data == 8'h0C);
    is_lf    = (chr.char_data == 8'h0A);
    is_cr    = (chr.char_data == 8'h0D);
    is_bs    = (chr.char_data == 8'h08);
    is_print = (chr.char_data >= 8'h20) &&
               (chr.char_data != 8'h7F);
  end

  // Physical row and RAM addresses for the cursor cell.
  always_comb begin
    row_sum = {1'b0, top_row} + {1'b0, cursor_y};
    if (row_sum >= 6'd30)
      prow = 5'(row_sum - 6'd30);
    else
      prow = row_sum[4:0];
    if (top_row == LAST_ROW)
      top_nxt = 5'd0;
    else
      top_nxt = top_row + 5'd1;
    row_base = mul70(prow);
    top_base = mul70(top_row);
    col_dec  = cursor_x - 7'd1;
    wr_addr  = row_base + {5'd0, cursor_x};
    bs_addr  = row_base + {5'd0, col_dec};
  end

  // Decide whether this accept moves to a new line.
  always_comb begin
    x_last = (cursor_x == LAST_COL);
    scroll = (cursor_y == LAST_ROW);
    do_adv = accept &
             (is_lf | (is_print & x_last));
  end

  // Control FSM and clear counter.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR_ALL;
      cnt      <= '0;
      clr_base <= '0;
    end else begin
      unique case (state)
        CLEAR_ALL: begin
          if (cnt == LAST_CELL) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        CLEAR_LINE: begin
          if (cnt == LINE_END) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        IDLE: begin
          if (accept & is_ff) begin
            state <= CLEAR_ALL;
            cnt   <= '0;
          end else if (do_adv & scroll) begin
            state    <= CLEAR_LINE;
            cnt      <= '0;
            clr_base <= top_base;
          end
        end
        default: begin
          state <= CLEAR_ALL;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Cursor column.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cursor_x <= '0;
    end else if (accept) begin
      unique case (1'b1)
        is_ff, is_lf, is_cr: begin
          cursor_x <= '0;
        end
        is_bs: begin
          if (cursor_x != 7'd0)
            cursor_x <= col_dec;
        end
        is_print: begin
          if (x_last)
            cursor_x <= '0;
          else
            cursor_x <= cursor_x + 7'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Cursor row and scroll offset.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cursor_y <= '0;
      top_row  <= '0;
    end else if (accept & is_ff) begin
      cursor_y <= '0;
      top_row  <= '0;
    end else if (do_adv) begin
      if (scroll)
        top_row <= top_nxt;
      else
        cursor_y <= cursor_y + 5'd1;
    end
  end

  // Registered RAM write port.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      ram_wren <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      ram_wren <= 1'b0;
      unique case (state)
        CLEAR_ALL: begin
          ram_wren <= 1'b1;
          ram_addr <= cnt;
          ram_data <= BLANK;
        end
        CLEAR_LINE: begin
          ram_wren <= 1'b1;
          ram_addr <= clr_base + cnt;
          ram_data <= BLANK;
        end
        IDLE: begin
          if (accept & is_print) begin
            ram_wren <= 1'b1;
            ram_addr <= wr_addr;
            ram_data <= chr.char_data;
          end else if (accept & is_bs &
                       (cursor_x != 7'd0)) begin
            ram_wren <= 1'b1;
            ram_addr <= bs_addr;
            ram_data <= BLANK;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
